// File: rtl/tk3_key_schedule_pkg.sv
// Shared types and constants for the masked SKINNY-128-384+ TK3 schedule.
package tk3_key_schedule_pkg;

  localparam int SKINNY_ROUNDS = 40;
  localparam int TK_W = 128;
  localparam int RK_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Cell permutation applied each round: new cell i = old cell PT[i].
  localparam int PT [16] = '{
    9, 15, 8, 13, 10, 14, 12, 11,
    0, 1, 2, 3, 4, 5, 6, 7
  };

  function automatic logic [7:0] lfsr3(input logic [7:0] x);
    return {x[0] ^ x[6], x[7:1]};
  endfunction

endpackage

// File: rtl/tk3_key_schedule_if.sv
// Handshake bundle between the round function and the TK3 key schedule.
interface tk3_key_schedule_if
  import tk3_key_schedule_pkg::*;
#(
  parameter int CNT_W = 6
);

  logic             key_load;
  logic [TK_W-1:0]  key_s0;
  logic [TK_W-1:0]  key_s1;
  logic             start;
  logic             step;
  logic [RK_W-1:0]  rk_s0;
  logic [RK_W-1:0]  rk_s1;
  logic [CNT_W-1:0] round_cnt;
  logic             busy;
  logic             done;

  modport master (
    output key_load, key_s0, key_s1,
    output start, step,
    input  rk_s0, rk_s1, round_cnt,
    input  busy, done
  );

  modport slave (
    input  key_load, key_s0, key_s1,
    input  start, step,
    output rk_s0, rk_s1, round_cnt,
    output busy, done
  );

endinterface

// File: rtl/tk3_key_schedule_key_expansion.sv
// One TK3 round update: cell permutation then LFSR on the top two rows.
module tk3_key_schedule_key_expansion
  import tk3_key_schedule_pkg::*;
(
  input  logic [TK_W-1:0] tk,
  output logic [TK_W-1:0] tk_next
);

  logic [TK_W-1:0] perm;

  always_comb begin
    perm = '0;
    for (int i = 0; i < 16; i++) begin
      perm[127-8*i -: 8] = tk[127-8*PT[i] -: 8];
    end
    tk_next = perm;
    for (int i = 0; i < 8; i++) begin
      tk_next[127-8*i -: 8] = lfsr3(perm[127-8*i -: 8]);
    end
  end

endmodule

// File: rtl/tk3_key_schedule.sv
// DOM1 two-share TK3 tweakey schedule; rewinds to the master key per block.
module tk3_key_schedule
  import tk3_key_schedule_pkg::*;
#(
  parameter int ROUNDS = SKINNY_ROUNDS,
  parameter int CNT_W  = 6
) (
  input logic clk,
  input logic rst_n,
  tk3_key_schedule_if.slave bus
);

  state_t state, state_d;

  logic [TK_W-1:0] m0, m1, w0, w1;
  logic [TK_W-1:0] m0_d, m1_d, w0_d, w1_d;
  logic [TK_W-1:0] x0, x1;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic busy, done;

  // Each share expands on its own; the update is linear so no mixing is needed.
  tk3_key_schedule_key_expansion u_kx0 (
    .tk      (w0),
    .tk_next (x0)
  );

  tk3_key_schedule_key_expansion u_kx1 (
    .tk      (w1),
    .tk_next (x1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      m0    <= '0;
      m1    <= '0;
      w0    <= '0;
      w1    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      m0    <= m0_d;
      m1    <= m1_d;
      w0    <= w0_d;
      w1    <= w1_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    m0_d    = m0;
    m1_d    = m1;
    w0_d    = w0;
    w1_d    = w1;
    cnt_d   = cnt;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.key_load) begin
          m0_d = bus.key_s0;
          m1_d = bus.key_s1;
          w0_d = bus.key_s0;
          w1_d = bus.key_s1;
        end else if (bus.start) begin
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (bus.step) begin
          w0_d = x0;
          w1_d = x1;
          if (cnt == CNT_W'(ROUNDS - 1)) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        w0_d    = m0;
        w1_d    = m1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rk_s0     = w0[TK_W-1 -: RK_W];
  assign bus.rk_s1     = w1[TK_W-1 -: RK_W];
  assign bus.round_cnt = cnt;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule
